// File: rtl/i2c_poll_sequencer.sv
// i2c_poll_sequencer
//   Sweeps a table of I2C sensors through an external byte-level master,
//   issuing one two-byte read per enabled channel, converting the raw word
//   (temperature or lux format) and publishing it per channel.
// Ports:
//   clk, rst (async, active-low)    clock and reset
//   enable                          run sweeps back to back while high
//   ch_enable[NUM_CH]               per-channel skip mask, sampled at SELECT
//   m_start/m_addr/m_rw/
//   m_two_bytes/m_data              request to the I2C master (read-only use)
//   m_ready/m_ack/m_read_data       master status and returned word
//   ch_data[16*NUM_CH]              converted result, channel i at [16i+15:16i]
//   ch_valid/ch_fault[NUM_CH]       channel holds a good sample / last poll failed
//   sample_strobe/sample_ch         one-cycle pulse when a channel updates
//   sweep_done                      one-cycle pulse at the end of a full sweep
module i2c_poll_sequencer #(
  parameter int                  NUM_CH     = 8,
  parameter logic [7*NUM_CH-1:0] ADDR_TABLE = {7'h47, 7'h46, 7'h45, 7'h44,
                                               7'h4B, 7'h4A, 7'h49, 7'h48},
  parameter logic [NUM_CH-1:0]   LUX_MASK   = 8'hF0,
  parameter int                  TIMEOUT    = 4096,
  parameter int                  MAX_RETRY  = 2,
  parameter int                  GAP        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_CH-1:0]      ch_enable,
  output logic                   m_start,
  output logic [6:0]             m_addr,
  output logic                   m_rw,
  output logic                   m_two_bytes,
  output logic [15:0]            m_data,
  input  logic                   m_ready,
  input  logic                   m_ack,
  input  logic [15:0]            m_read_data,
  output logic [16*NUM_CH-1:0]   ch_data,
  output logic [NUM_CH-1:0]      ch_valid,
  output logic [NUM_CH-1:0]      ch_fault,
  output logic                   sample_strobe,
  output logic [3:0]             sample_ch,
  output logic                   sweep_done
);

  localparam int PW = 5;
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_GAP
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr;
  logic [3:0]      ch4;
  logic [TW-1:0]   tmo_cnt;
  logic [1:0]      busy_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [RW-1:0]   retry_cnt;
  logic            retry_pend;
  logic [15:0]     en_ext, lux_ext;
  logic [6:0]      addr_cur;
  logic            tmo_exp, gap_last;
  logic            ptr_clr, ptr_inc, done_ok, done_fail, sweep_end;
  logic [15:0]     conv;

  // Temperature word: upper 9 bits are a two's-complement value in 1 C steps.
  function automatic logic signed [15:0] temp_conv(input logic [15:0] raw);
    logic signed [8:0] deg;
    deg = signed'(raw[15:7]);
    return {{7{deg[8]}}, deg};
  endfunction

  // Lux word: 12-bit mantissa scaled by 2^exponent, clamped to 16 bits.
  function automatic logic [15:0] lux_conv(input logic [15:0] raw);
    logic [27:0] wide;
    wide = {16'h0000, raw[11:0]} << raw[15:12];
    return (|wide[27:16]) ? 16'hFFFF : wide[15:0];
  endfunction

  assign m_rw        = 1'b1;
  assign m_two_bytes = 1'b1;
  assign m_data      = 16'h0000;

  assign ch4      = ptr[3:0];
  assign en_ext   = 16'(ch_enable);
  assign lux_ext  = 16'(LUX_MASK);
  assign addr_cur = 7'(ADDR_TABLE >> (7 * ch4));
  assign tmo_exp  = (32'(tmo_cnt) >= TIMEOUT);
  assign gap_last = (gap_cnt == GW'(GAP - 1));
  assign conv     = lux_ext[ch4] ? lux_conv(m_read_data) : 16'(temp_conv(m_read_data));

  always_comb begin
    state_n   = state;
    m_start   = 1'b0;
    m_addr    = 7'h00;
    ptr_clr   = 1'b0;
    ptr_inc   = 1'b0;
    done_ok   = 1'b0;
    done_fail = 1'b0;
    sweep_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && m_ready) begin
          ptr_clr = 1'b1;
          state_n = S_SELECT;
        end
      end
      S_SELECT: begin
        if (!enable) begin
          state_n = S_IDLE;
        end else if (ptr >= PW'(NUM_CH)) begin
          sweep_end = 1'b1;
          state_n   = S_IDLE;
        end else if (en_ext[ch4]) begin
          state_n = S_ISSUE;
        end else begin
          ptr_inc = 1'b1;
        end
      end
      S_ISSUE: begin
        m_addr = addr_cur;
        if (m_ready) begin
          m_start = 1'b1;
          state_n = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        // A master that never drops ready has not accepted the request.
        if (!m_ready) begin
          state_n = S_WAIT_DONE;
        end else if (busy_cnt == 2'd3 || tmo_exp) begin
          done_fail = 1'b1;
          state_n   = S_GAP;
        end
      end
      S_WAIT_DONE: begin
        if (m_ready) begin
          done_ok   = m_ack;
          done_fail = !m_ack;
          state_n   = S_GAP;
        end else if (tmo_exp) begin
          done_fail = 1'b1;
          state_n   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_last) begin
          if (retry_pend) begin
            state_n = S_ISSUE;
          end else begin
            ptr_inc = 1'b1;
            state_n = enable ? S_SELECT : S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      ptr           <= '0;
      tmo_cnt       <= '0;
      busy_cnt      <= '0;
      gap_cnt       <= '0;
      retry_cnt     <= '0;
      retry_pend    <= 1'b0;
      ch_data       <= '0;
      ch_valid      <= '0;
      ch_fault      <= '0;
      sample_strobe <= 1'b0;
      sample_ch     <= 4'h0;
      sweep_done    <= 1'b0;
    end else begin
      state         <= state_n;
      sample_strobe <= done_ok;
      sweep_done    <= sweep_end;

      if (ptr_clr)      ptr <= '0;
      else if (ptr_inc) ptr <= ptr + 1'b1;

      // Timeout window opens on the start cycle and covers both wait states.
      if (m_start)
        tmo_cnt <= TW'(1);
      else if (state == S_WAIT_BUSY || state == S_WAIT_DONE)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;

      busy_cnt <= (state == S_WAIT_BUSY) ? busy_cnt + 1'b1 : 2'd0;
      gap_cnt  <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;

      if (done_fail) begin
        if (retry_cnt < RW'(MAX_RETRY)) begin
          retry_cnt  <= retry_cnt + 1'b1;
          retry_pend <= 1'b1;
        end else begin
          retry_pend <= 1'b0;
          for (int i = 0; i < NUM_CH; i++)
            if (ptr == PW'(i)) ch_fault[i] <= 1'b1;
        end
      end

      if (done_ok) begin
        retry_pend <= 1'b0;
        sample_ch  <= ch4;
        for (int i = 0; i < NUM_CH; i++) begin
          if (ptr == PW'(i)) begin
            ch_data[16*i +: 16] <= conv;
            ch_valid[i]         <= 1'b1;
            ch_fault[i]         <= 1'b0;
          end
        end
      end

      if (ptr_clr || ptr_inc) retry_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// tb_i2c_poll_sequencer
//   Directed bench for i2c_poll_sequencer with a behavioural I2C master
//   responder driven from per-address response tables.
module tb_i2c_poll_sequencer;

  localparam int NUM_CH    = 8;
  localparam int TIMEOUT   = 4096;
  localparam int MAX_RETRY = 2;
  localparam int GAP       = 16;

  logic                 clk, rst, enable;
  logic [NUM_CH-1:0]    ch_enable;
  logic                 m_start, m_rw, m_two_bytes;
  logic [6:0]           m_addr;
  logic [15:0]          m_data;
  logic                 m_ready, m_ack;
  logic [15:0]          m_read_data;
  logic [16*NUM_CH-1:0] ch_data;
  logic [NUM_CH-1:0]    ch_valid, ch_fault;
  logic                 sample_strobe, sweep_done;
  logic [3:0]           sample_ch;

  i2c_poll_sequencer #(
    .NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_enable(ch_enable),
    .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_two_bytes(m_two_bytes),
    .m_data(m_data), .m_ready(m_ready), .m_ack(m_ack), .m_read_data(m_read_data),
    .ch_data(ch_data), .ch_valid(ch_valid), .ch_fault(ch_fault),
    .sample_strobe(sample_strobe), .sample_ch(sample_ch), .sweep_done(sweep_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Response tables indexed by slave address. mode: 0 normal, 1 ready never
  // drops, 2 ready stuck low past the timeout.
  logic [15:0] rsp_data [128];
  logic        rsp_ack  [128];
  int          rsp_mode [128];
  int          rsp_lat  [128];

  initial begin
    logic [6:0] a;
    m_ready     = 1'b1;
    m_ack       = 1'b0;
    m_read_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (m_start === 1'b1) begin
        a = m_addr;
        if (rsp_mode[a] == 0) begin
          @(posedge clk); #1;
          m_ready = 1'b0;
          m_ack   = 1'b0;
          repeat (rsp_lat[a]) @(posedge clk);
          #1;
          m_read_data = rsp_data[a];
          m_ack       = rsp_ack[a];
          m_ready     = 1'b1;
        end else if (rsp_mode[a] == 2) begin
          @(posedge clk); #1;
          m_ready = 1'b0;
          repeat (TIMEOUT + 4) @(posedge clk);
          #1;
          m_ready = 1'b1;
        end
      end
    end
  end

  logic [6:0]  addr_q[$];
  int unsigned cyc_q[$];
  logic [3:0]  strobe_q[$];
  int unsigned cyc    = 0;
  int          n_done = 0;
  int          n_both = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (m_start === 1'b1) begin
        addr_q.push_back(m_addr);
        cyc_q.push_back(cyc);
      end
      if (sample_strobe === 1'b1) strobe_q.push_back(sample_ch);
      if (sweep_done === 1'b1) n_done++;
      if (sample_strobe === 1'b1 && sweep_done === 1'b1) n_both++;
    end
  end

  int cmp   = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmp++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sweep(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (sweep_done !== 1'b1 && k < budget);
    if (sweep_done !== 1'b1) begin
      cmp++;
      fails++;
      $error("FAIL sweep_timeout: observed no sweep_done expected pulse within %0d cycles", budget);
    end
    enable = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (addr_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (addr_q.size() < n) begin
      cmp++;
      fails++;
      $error("FAIL start_timeout: observed %0d starts expected %0d", addr_q.size(), n);
    end
  endtask

  task automatic chk_addrs(input string tag, input int base, input logic [6:0] exp[$]);
    chk({tag, "_count"}, 128'(addr_q.size() - base), 128'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (base + i < addr_q.size())
        chk({tag, "_addr"}, 128'(addr_q[base + i]), 128'(exp[i]));
  endtask

  initial begin
    int          base, sbase, dbase;
    int unsigned d;
    logic [6:0]  exp_a[$];

    for (int i = 0; i < 128; i++) begin
      rsp_data[i] = 16'h0000;
      rsp_ack[i]  = 1'b1;
      rsp_mode[i] = 0;
      rsp_lat[i]  = 2;
    end
    rsp_data[7'h48] = 16'h1900;  // temp  50 C
    rsp_data[7'h49] = 16'hFF80;  // temp  -1 C
    rsp_data[7'h4A] = 16'h7F80;  // temp 255 C
    rsp_data[7'h4B] = 16'h0C80;  // temp  25 C
    rsp_data[7'h44] = 16'h3064;  // lux 100<<3
    rsp_data[7'h45] = 16'h0001;  // lux 1<<0
    rsp_data[7'h46] = 16'h1FFF;  // lux FFF<<1
    rsp_data[7'h47] = 16'h4FFF;  // lux FFF<<4, just fits

    rst = 1'b0;
    enable = 1'b0;
    ch_enable = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_ch_data", 128'(ch_data), 128'h0);
    chk("rst_ch_valid", 128'(ch_valid), 128'h0);
    chk("rst_ch_fault", 128'(ch_fault), 128'h0);
    chk("rst_strobe", 128'(sample_strobe), 128'h0);
    chk("rst_sample_ch", 128'(sample_ch), 128'h0);
    chk("rst_sweep_done", 128'(sweep_done), 128'h0);
    chk("rst_m_start", 128'(m_start), 128'h0);
    chk("rst_m_addr", 128'(m_addr), 128'h0);
    chk("m_rw", 128'(m_rw), 128'h1);
    chk("m_two_bytes", 128'(m_two_bytes), 128'h1);
    chk("m_data", 128'(m_data), 128'h0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_no_start", 128'(addr_q.size()), 128'h0);

    // Sweep 1: every channel acknowledges.
    enable = 1'b1;
    wait_sweep(3000);
    exp_a = '{7'h48, 7'h49, 7'h4A, 7'h4B, 7'h44, 7'h45, 7'h46, 7'h47};
    chk_addrs("s1", 0, exp_a);
    chk("s1_strobes", 128'(strobe_q.size()), 128'd8);
    if (strobe_q.size() > 0) chk("s1_first_sample_ch", 128'(strobe_q[0]), 128'h0);
    chk("s1_ch0", 128'(ch_data[0*16 +: 16]), 128'h0032);
    chk("s1_ch1", 128'(ch_data[1*16 +: 16]), 128'hFFFF);
    chk("s1_ch2", 128'(ch_data[2*16 +: 16]), 128'h00FF);
    chk("s1_ch3", 128'(ch_data[3*16 +: 16]), 128'h0019);
    chk("s1_ch4", 128'(ch_data[4*16 +: 16]), 128'h0320);
    chk("s1_ch5", 128'(ch_data[5*16 +: 16]), 128'h0001);
    chk("s1_ch6", 128'(ch_data[6*16 +: 16]), 128'h1FFE);
    chk("s1_ch7", 128'(ch_data[7*16 +: 16]), 128'hFFF0);
    chk("s1_valid", 128'(ch_valid), 128'hFF);
    chk("s1_fault", 128'(ch_fault), 128'h00);
    chk("s1_done", 128'(n_done), 128'd1);

    // Sweep 2: ch2 NACKs every attempt, ch4 saturates.
    base = addr_q.size();
    rsp_ack[7'h4A]  = 1'b0;
    rsp_data[7'h44] = 16'hF800;
    enable = 1'b1;
    wait_sweep(3000);
    exp_a = '{7'h48, 7'h49, 7'h4A, 7'h4A, 7'h4A, 7'h4B, 7'h44, 7'h45, 7'h46, 7'h47};
    chk_addrs("s2", base, exp_a);
    chk("s2_fault", 128'(ch_fault), 128'h04);
    chk("s2_ch2_kept", 128'(ch_data[2*16 +: 16]), 128'h00FF);
    chk("s2_ch2_valid", 128'(ch_valid[2]), 128'h1);
    chk("s2_ch4_sat", 128'(ch_data[4*16 +: 16]), 128'hFFFF);

    // Sweep 3: ch2 ready never drops, ch3 ready stuck low.
    base = addr_q.size();
    rsp_ack[7'h4A]  = 1'b1;
    rsp_mode[7'h4A] = 1;
    rsp_mode[7'h4B] = 2;
    enable = 1'b1;
    wait_sweep(20000);
    exp_a = '{7'h48, 7'h49, 7'h4A, 7'h4A, 7'h4A, 7'h4B, 7'h4B, 7'h4B,
              7'h44, 7'h45, 7'h46, 7'h47};
    chk_addrs("s3", base, exp_a);
    chk("s3_fault", 128'(ch_fault), 128'h0C);
    chk("s3_ch3_kept", 128'(ch_data[3*16 +: 16]), 128'h0019);
    if (cyc_q.size() >= base + 7) begin
      d = cyc_q[base + 6] - cyc_q[base + 5];
      chk("s3_stuck_interval_in_window",
          128'(d >= TIMEOUT && d <= TIMEOUT + GAP + 8), 128'h1);
    end

    // Sweep 4: only ch0 and ch2 enabled.
    base  = addr_q.size();
    dbase = n_done;
    rsp_mode[7'h4A] = 0;
    rsp_mode[7'h4B] = 0;
    ch_enable = 8'b0000_0101;
    enable = 1'b1;
    wait_sweep(3000);
    exp_a = '{7'h48, 7'h4A};
    chk_addrs("s4", base, exp_a);
    chk("s4_done_pulses", 128'(n_done - dbase), 128'd1);
    chk("s4_fault", 128'(ch_fault), 128'h08);

    // Enable dropped while ch1 is in flight.
    base  = addr_q.size();
    sbase = strobe_q.size();
    dbase = n_done;
    ch_enable = 8'hFF;
    rsp_lat[7'h49]  = 30;
    rsp_data[7'h49] = 16'h0A00;
    enable = 1'b1;
    wait_starts(base + 2, 500);
    enable = 1'b0;
    repeat (100) @(negedge clk);
    chk("en_drop_starts", 128'(addr_q.size() - base), 128'd2);
    chk("en_drop_strobes", 128'(strobe_q.size() - sbase), 128'd2);
    if (strobe_q.size() > 0)
      chk("en_drop_last_ch", 128'(strobe_q[strobe_q.size() - 1]), 128'h1);
    chk("en_drop_ch1", 128'(ch_data[1*16 +: 16]), 128'h0014);
    chk("en_drop_no_done", 128'(n_done - dbase), 128'd0);

    // Reset while ch5 waits for its response.
    base = addr_q.size();
    rsp_lat[7'h49] = 2;
    rsp_lat[7'h45] = 60;
    enable = 1'b1;
    wait_starts(base + 6, 2000);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ch_data", 128'(ch_data), 128'h0);
    chk("mid_rst_valid", 128'(ch_valid), 128'h0);
    chk("mid_rst_fault", 128'(ch_fault), 128'h0);
    chk("mid_rst_m_start", 128'(m_start), 128'h0);
    chk("mid_rst_m_addr", 128'(m_addr), 128'h0);
    chk("mid_rst_strobe", 128'(sample_strobe), 128'h0);
    chk("mid_rst_sample_ch", 128'(sample_ch), 128'h0);
    chk("mid_rst_sweep_done", 128'(sweep_done), 128'h0);
    @(negedge clk);
    rst = 1'b1;
    base = addr_q.size();
    wait_starts(base + 1, 500);
    enable = 1'b0;
    if (addr_q.size() > base) chk("post_rst_first_addr", 128'(addr_q[base]), 128'h48);
    repeat (GAP + 80) @(negedge clk);
    chk("post_rst_ch5_clear", 128'(ch_data[5*16 +: 16]), 128'h0);
    chk("post_rst_ch0", 128'(ch_data[0*16 +: 16]), 128'h0032);
    chk("strobe_done_exclusive", 128'(n_both), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end

endmodule
